// File: rtl/spmv_read_ctrl.sv
// SpMV row read controller: sequences SRAM0 input-vector and matrix-value block
// reads, then streams matrix-value indices to the MAC under a ready handshake.
module spmv_read_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_nnz,
  input  logic             i_abort,
  input  logic             i_pe_ready,
  input  logic             i_host_req,
  output logic             o_host_gnt,
  output logic             o_read_start_IV,
  output logic             o_read_start_MV,
  output logic [CNT_W-1:0] o_count,
  output logic             o_val_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [2:0]       o_state
);

  localparam int unsigned WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IV      = 3'd1,
    IV_WAIT = 3'd2,
    MV      = 3'd3,
    MV_WAIT = 3'd4,
    STREAM  = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [CNT_W-1:0]   remaining, remaining_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic               wait_last;

  assign wait_last = (wait_cnt == WAIT_W'(WAIT_CYC - 1));

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      count     <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      remaining <= remaining_nxt;
      wait_cnt  <= wait_nxt;
    end
  end

  // Next-state logic; abort overrides every transition including a handshake
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    remaining_nxt = remaining;
    wait_nxt      = wait_cnt;
    if (i_abort && (state != IDLE)) begin
      state_nxt = IDLE;
      wait_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start && !i_host_req) begin
            if (i_nnz == '0) begin
              state_nxt = DONE;
            end else begin
              remaining_nxt = i_nnz;
              count_nxt     = '0;
              state_nxt     = IV;
            end
          end
        end
        IV: begin
          wait_nxt  = '0;
          state_nxt = (WAIT_CYC == 0) ? MV : IV_WAIT;
        end
        IV_WAIT: begin
          if (wait_last) begin
            wait_nxt  = '0;
            state_nxt = MV;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
        MV: begin
          wait_nxt  = '0;
          state_nxt = (WAIT_CYC == 0) ? STREAM : MV_WAIT;
        end
        MV_WAIT: begin
          if (wait_last) begin
            wait_nxt  = '0;
            state_nxt = STREAM;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
        STREAM: begin
          if (i_pe_ready) begin
            count_nxt     = count + CNT_W'(1);
            remaining_nxt = remaining - CNT_W'(1);
            // Last value finishes the row; a block boundary triggers a refill
            if (remaining == CNT_W'(1)) begin
              state_nxt = DONE;
            end else if (count_nxt[3:0] == 4'd0) begin
              state_nxt = MV;
            end
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign o_host_gnt      = (state == IDLE) & i_host_req;
  assign o_read_start_IV = (state == IV);
  assign o_read_start_MV = (state == MV);
  assign o_val_valid     = (state == STREAM);
  assign o_busy          = (state != IDLE);
  assign o_done          = (state == DONE);
  assign o_count         = count;
  assign o_state         = state;

endmodule
